capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter dsize, default 32, sample width in bits.
REQ-002 Parameter aw, default 10, buffer address width; depth D = 2^aw samples.
REQ-003 clk  in  1  clock; every register changes on the rising edge only.
REQ-004 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-005 start  in  1  one-cycle pulse that begins a capture; honoured only in IDLE or DONE.
REQ-006 cancel  in  1  abandons the capture in progress.
REQ-007 divider  in  16  sample period minus one, in clk cycles.
REQ-008 pre_count  in  aw  samples retained before the trigger.
REQ-009 post_count  in  aw+1  samples captured from the trigger onward.
REQ-010 dinput  in  dsize  probe inputs, shared with the trigger stage.
REQ-011 triggered  in  1  trigger-stage done flag.
REQ-012 trig_armed  in  1  trigger-stage armed flag.
REQ-013 arm  out  1  one-cycle pulse that arms the trigger stage.
REQ-014 abort  out  1  one-cycle pulse that aborts the trigger stage.
REQ-015 ignore  out  1  low only on sample-strobe cycles; drives the trigger-stage ignore input.
REQ-016 out_data  out  dsize  readout sample.
REQ-017 out_valid  out  1  out_data holds a valid sample.
REQ-018 out_ready  in  1  the consumer accepts the sample.
REQ-019 out_last  out  1  marks the final sample of the record.
REQ-020 state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, READ=4, DONE=5.

Function
REQ-021 Strobe counter: counts 0..divider, then wraps to 0; strobe = (count == divider); ignore = ~strobe; divider = 0 gives a strobe every cycle.
REQ-022 Strobe counter runs in every state except IDLE and DONE, where it is held at 0.
REQ-023 In PRE, ARMED and POST, each strobe writes dinput to mem[wr_ptr], then wr_ptr increments modulo D.
REQ-024 IDLE/DONE + start: go to PRE, clear wr_ptr and the fill count.
REQ-025 PRE: count strobes; when the fill count reaches pre_count, go to ARMED and pulse arm; pre_count = 0 makes the transition immediate.
REQ-026 ARMED: continue circular writes.
REQ-027 ARMED, on the first cycle with triggered = 1: latch trig_addr = wr_ptr, go to POST.
REQ-028 The trigger condition in REQ-027 ignores triggered for 2 cycles after the arm pulse, so a stale done flag is not used.
REQ-029 POST: the first post sample is written at trig_addr.
REQ-030 POST: after post_eff strobes, go to READ.
REQ-031 post_eff = min(post_count, D - pre_count); post_eff = 0 goes straight to READ.
REQ-032 READ: stream pre_count + post_eff samples, oldest first, starting at (trig_addr - pre_count) mod D.
REQ-033 Readout handshake: a transfer occurs on a cycle with out_valid & out_ready.
REQ-034 While out_valid = 1 and out_ready = 0, out_data, out_valid and out_last are held stable.
REQ-035 First out_valid within 2 cycles of entering READ; sustained throughput is 1 sample/cycle while out_ready = 1.
REQ-036 out_last = 1 only with the final sample; that transfer moves the FSM to DONE.
REQ-037 A record length of 0 goes to DONE with no out_valid.
REQ-038 cancel in PRE/POST/READ: go to IDLE next cycle, drop out_valid.
REQ-039 cancel in ARMED, or in any state while trig_armed = 1: pulse abort for 1 cycle, then go to IDLE.
REQ-040 cancel and start in the same cycle: cancel wins.
REQ-041 A start received outside IDLE/DONE is ignored.
REQ-042 Circular wrap: wr_ptr and read pointer arithmetic are modulo D; a record never exceeds D samples.

Reset
REQ-043 While reset = 1, state = IDLE.
REQ-044 While reset = 1, wr_ptr = 0, strobe counter = 0, arm = 0, abort = 0, ignore = 1, out_valid = 0, out_last = 0, out_data = 0.
REQ-045 A reset asserted mid-capture or mid-readout takes priority over all inputs; buffer contents are don't-care.

Verification
REQ-046 aw=4, divider=0, pre=3, post=5, dinput = cycle count, triggered raised at ARMED+6 -> 8 samples out in order, last 5 starting at the trigger-cycle value, out_last on the 8th.
REQ-047 divider=3 -> ignore low exactly 1 cycle in 4; PRE with pre=2 lasts 8 cycles before arm.
REQ-048 out_ready toggling 1010... during READ -> no lost or duplicated samples; data held while stalled.
REQ-049 aw=4, pre=10, post=12 -> post_eff=6, 16 samples out; wr_ptr wrap exercised.
REQ-050 cancel in ARMED -> abort pulses once, state=IDLE, no out_valid; cancel with start same cycle -> remains IDLE.
REQ-051 reset asserted during READ after 3 transfers -> outputs per REQ-044 next cycle; a new start runs a full clean capture.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture sequencer for a logic analyser: circular pre-trigger buffering,
// post-trigger fill, then an oldest-first valid/ready readout of the record.
module capture_ctrl #(
    parameter int unsigned dsize = 32,
    parameter int unsigned aw    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [15:0]      divider,
    input  logic [aw-1:0]    pre_count,
    input  logic [aw:0]      post_count,
    input  logic [dsize-1:0] dinput,
    input  logic             triggered,
    input  logic             trig_armed,
    output logic             arm,
    output logic             abort,
    output logic             ignore,
    output logic [dsize-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [2:0]       state
);

    localparam int unsigned depth = 1 << aw;
    localparam int unsigned cnt_w = aw + 1;

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_pre   = 3'd1;
    localparam logic [2:0] st_armed = 3'd2;
    localparam logic [2:0] st_post  = 3'd3;
    localparam logic [2:0] st_read  = 3'd4;
    localparam logic [2:0] st_done  = 3'd5;

    logic [2:0]       st_q, st_d;
    logic [15:0]      div_cnt, div_cnt_d;
    logic [aw-1:0]    wr_ptr, rd_ptr;
    logic [cnt_w-1:0] fill, post_cnt, loads_left, pre_q, post_eff_q;
    logic [cnt_w-1:0] room_c, post_eff_c;
    logic [1:0]       armed_age;
    logic [dsize-1:0] mem [depth];

    logic idle_c, active_d_c, strobe_c, write_c, start_ok_c, trig_c;
    logic post_now_c, pre_done_c, post_done_c, xfer_c, load_c;

    assign state = st_q;

    // Per-cycle decode of strobe, capture writes, trigger and readout events
    always_comb begin
        idle_c      = (st_q == st_idle) || (st_q == st_done);
        strobe_c    = !idle_c && (div_cnt == divider);
        write_c     = strobe_c && ((st_q == st_pre) || (st_q == st_armed) || (st_q == st_post));
        start_ok_c  = idle_c && start && !cancel;
        // Holdoff of the arm cycle plus two more keeps a stale done flag out
        trig_c      = (st_q == st_armed) && (armed_age == 2'd3) && triggered;
        post_now_c  = (post_eff_q == '0) || (strobe_c && (post_eff_q == cnt_w'(1)));
        pre_done_c  = (fill == pre_q) || (strobe_c && ((fill + cnt_w'(1)) == pre_q));
        post_done_c = strobe_c && ((post_cnt + cnt_w'(1)) == post_eff_q);
        xfer_c      = out_valid && out_ready;
        load_c      = (st_q == st_read) && (loads_left != '0) && (!out_valid || out_ready);
        room_c      = cnt_w'(depth) - {1'b0, pre_count};
        post_eff_c  = (post_count < room_c) ? post_count : room_c;
    end

    // Next-state logic; cancel overrides every other input
    always_comb begin
        st_d = st_q;
        if (cancel) begin
            st_d = st_idle;
        end else begin
            case (st_q)
                st_idle, st_done: if (start) st_d = st_pre;
                st_pre:           if (pre_done_c) st_d = st_armed;
                st_armed:         if (trig_c) st_d = post_now_c ? st_read : st_post;
                st_post:          if (post_done_c) st_d = st_read;
                st_read: begin
                    if ((xfer_c && out_last) || ((loads_left == '0) && !out_valid))
                        st_d = st_done;
                end
                default:          st_d = st_idle;
            endcase
        end
    end

    // Sample-period counter, parked at zero outside an active capture
    always_comb begin
        active_d_c = !((st_d == st_idle) || (st_d == st_done));
        div_cnt_d  = div_cnt + 16'd1;
        if (idle_c || !active_d_c || strobe_c)
            div_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= st_idle;
            div_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            post_cnt   <= '0;
            loads_left <= '0;
            pre_q      <= '0;
            post_eff_q <= '0;
            armed_age  <= '0;
            arm        <= 1'b0;
            abort      <= 1'b0;
            ignore     <= 1'b1;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            st_q    <= st_d;
            div_cnt <= div_cnt_d;
            ignore  <= !(active_d_c && (div_cnt_d == divider));
            arm     <= (st_q == st_pre) && (st_d == st_armed);
            abort   <= cancel && ((st_q == st_armed) || trig_armed);

            if (start_ok_c) begin
                wr_ptr     <= '0;
                fill       <= '0;
                pre_q      <= {1'b0, pre_count};
                post_eff_q <= post_eff_c;
            end else begin
                if (write_c)
                    wr_ptr <= wr_ptr + aw'(1);
                if ((st_q == st_pre) && strobe_c)
                    fill <= fill + cnt_w'(1);
            end

            if (st_q != st_armed)
                armed_age <= '0;
            else if (armed_age != 2'd3)
                armed_age <= armed_age + 2'd1;

            // The trigger-cycle strobe already counts as the first post sample
            if (trig_c)
                post_cnt <= strobe_c ? cnt_w'(1) : '0;
            else if ((st_q == st_post) && strobe_c)
                post_cnt <= post_cnt + cnt_w'(1);

            // Record start is (trigger address - pre) modulo the buffer depth
            if (trig_c) begin
                rd_ptr     <= wr_ptr - aw'(pre_q);
                loads_left <= pre_q + post_eff_q;
            end else if (load_c) begin
                rd_ptr     <= rd_ptr + aw'(1);
                loads_left <= loads_left - cnt_w'(1);
            end

            if (cancel || (st_q != st_read)) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (load_c) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                out_last  <= (loads_left == cnt_w'(1));
            end else if (xfer_c) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Sample buffer; contents are not reset
    always_ff @(posedge clk) begin
        if (write_c && !reset)
            mem[wr_ptr] <= dinput;
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised bench for capture_ctrl: expected records come from a strobe-time
// model (which input cycles were sampled), not from the controller's structure.
module tb_capture_ctrl;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned AW    = 4;
    localparam int          D     = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic             cancel;
    logic [15:0]      divider;
    logic [AW-1:0]    pre_count;
    logic [AW:0]      post_count;
    logic [DSIZE-1:0] dinput;
    logic             triggered;
    logic             trig_armed;
    logic             arm;
    logic             abort;
    logic             ignore;
    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [2:0]       state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    capture_ctrl #(.dsize(DSIZE), .aw(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cancel     (cancel),
        .divider    (divider),
        .pre_count  (pre_count),
        .post_count (post_count),
        .dinput     (dinput),
        .triggered  (triggered),
        .trig_armed (trig_armed),
        .arm        (arm),
        .abort      (abort),
        .ignore     (ignore),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock; inputs for the new cycle are driven after this returns
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        dinput = DSIZE'(cyc);
    endtask

    // Cycle c is a sample strobe when start was taken in cycle s
    function automatic bit is_strobe(input int c, input int s, input int div);
        return (c > s) && (((c - s - 1) % (div + 1)) == div);
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_state"}, 64'(state), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_last"},  64'(out_last), 64'(0));
        check({tag, "_data"},  64'(out_data), 64'(0));
        check({tag, "_arm"},   64'(arm), 64'(0));
        check({tag, "_abort"}, 64'(abort), 64'(0));
        check({tag, "_ignore"}, 64'(ignore), 64'(1));
    endtask

    // intr: 0 none, 1 reset after 3 transfers, 2 cancel after 2 transfers
    task automatic run_capture(input int div, input int pre, input int post, input int k,
                               input int rmode, input int intr, input bit poke);
        int s, a, t, pe, n, l_cyc, rentry, c, cnt, got, first_v, last_x;
        int exp_q[$];
        bit prev_stall, done, rdy;
        logic [DSIZE-1:0] prev_data;
        logic prev_last;

        divider    = 16'(div);
        pre_count  = AW'(pre);
        post_count = (AW+1)'(post);
        pe = (post < D - pre) ? post : D - pre;
        n  = pre + pe;
        triggered  = 1'b1;
        trig_armed = 1'b0;
        out_ready  = 1'b0;
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;

        a = s + 1 + ((pre == 0) ? 1 : pre * (div + 1));
        t = a + k;
        c = t - 1;
        while (exp_q.size() < pre && c > s) begin
            if (is_strobe(c, s, div)) exp_q.push_front(c);
            c--;
        end
        c = t; cnt = 0; l_cyc = t;
        while (cnt < pe) begin
            if (is_strobe(c, s, div)) begin
                exp_q.push_back(c);
                l_cyc = c;
                cnt++;
            end
            c++;
        end
        rentry = l_cyc + 1;

        while (cyc < rentry) begin
            triggered = (cyc < a + 2) || (cyc >= t);
            start     = poke && (cyc == a + 1);
            check("state", 64'(state), (cyc < a) ? 64'(1) : ((cyc <= t) ? 64'(2) : 64'(3)));
            check("arm", 64'(arm), 64'(cyc == a));
            check("ignore", 64'(ignore), 64'(!is_strobe(cyc, s, div)));
            tick();
        end
        start = 1'b0;
        triggered = 1'b0;
        check("read_entry", 64'(state), 64'(4));

        got = 0; first_v = -1; last_x = -1; prev_stall = 1'b0; done = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 10 * n + 20 && !done; i++) begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && first_v < 0) first_v = cyc;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - rentry) % 2) == 0;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (got < n) begin
                    check("data", 64'(out_data), 64'(exp_q[got]));
                    check("last", 64'(out_last), 64'(got == n - 1));
                end else begin
                    check("extra_xfer", 64'(got), 64'(n));
                end
                got++;
                last_x = cyc;
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_last  = out_last;
            if (intr != 0 && got == ((intr == 1) ? 3 : 2)) begin
                tick();
                if (intr == 1) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    out_ready = 1'b0;
                    reset_checks("mid_read_reset");
                end else begin
                    cancel = 1'b1;
                    tick();
                    cancel = 1'b0;
                    out_ready = 1'b0;
                    check("read_cancel_state", 64'(state), 64'(0));
                    check("read_cancel_valid", 64'(out_valid), 64'(0));
                    check("read_cancel_abort", 64'(abort), 64'(0));
                end
                return;
            end
            tick();
            done = (state != 3'd4);
        end
        out_ready = 1'b0;
        check("count", 64'(got), 64'(n));
        check("done_state", 64'(state), 64'(5));
        check("done_valid", 64'(out_valid), 64'(0));
        if (n == 0)
            check("no_valid", 64'(first_v < 0), 64'(1));
        else
            check("first_latency", 64'(first_v > rentry && first_v <= rentry + 2), 64'(1));
        if (rmode == 0 && n > 0)
            check("throughput", 64'(last_x - first_v), 64'(n - 1));
    endtask

    task automatic cancel_tests();
        int s, a;
        // Cancel while armed, with the trigger stage reporting armed
        divider = 16'd0; pre_count = AW'(2); post_count = (AW+1)'(4);
        triggered = 1'b0; trig_armed = 1'b0;
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        a = s + 3;
        while (cyc < a + 1) tick();
        check("pre_cancel_armed", 64'(state), 64'(2));
        cancel = 1'b1; trig_armed = 1'b1;
        tick();
        cancel = 1'b0; trig_armed = 1'b0;
        check("cancel_abort_hi", 64'(abort), 64'(1));
        check("cancel_state", 64'(state), 64'(0));
        check("cancel_valid", 64'(out_valid), 64'(0));
        tick();
        check("cancel_abort_lo", 64'(abort), 64'(0));
        for (int i = 0; i < 4; i++) begin
            check("cancel_idle", 64'(state), 64'(0));
            check("cancel_no_valid", 64'(out_valid), 64'(0));
            tick();
        end
        // Cancel and start together from IDLE
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_state", 64'(state), 64'(0));
        check("cancel_start_abort", 64'(abort), 64'(0));
        tick();
        check("cancel_start_state2", 64'(state), 64'(0));
        // Cancel during PRE without an armed trigger stage
        pre_count = AW'(4);
        start = 1'b1; tick(); start = 1'b0;
        check("pre_state", 64'(state), 64'(1));
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("pre_cancel_state", 64'(state), 64'(0));
        check("pre_cancel_abort", 64'(abort), 64'(0));
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; divider = '0;
        pre_count = '0; post_count = '0; dinput = '0; triggered = 1'b0;
        trig_armed = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset_checks("reset");
        reset = 1'b0;
        tick();
        reset_checks("idle");

        run_capture(0, 3, 5, 6, 0, 0, 1'b0);
        run_capture(3, 2, 4, 5, 0, 0, 1'b1);
        run_capture(1, 4, 6, 4, 1, 0, 1'b0);
        run_capture(0, 10, 12, 3, 0, 0, 1'b1);
        run_capture(2, 0, 0, 3, 0, 0, 1'b0);
        run_capture(0, 0, 1, 4, 0, 0, 1'b0);
        run_capture(0, 15, 9, 5, 1, 0, 1'b0);
        cancel_tests();
        run_capture(0, 5, 6, 4, 0, 1, 1'b0);
        run_capture(1, 5, 6, 5, 2, 0, 1'b0);
        run_capture(0, 3, 3, 3, 0, 2, 1'b0);
        run_capture(0, 2, 3, 3, 0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run_capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 20)), int'($urandom_range(3, 10)),
                        int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
